// File: rtl/register_file_4w_32b_1r_128b.sv
// Flop register file: N_WRITE staged 32b byte-enabled write ports, one 128b row read port.
// Same-word collisions resolve per byte in favour of the highest-indexed port.

module register_file_4w_32b_1r_128b_chk #(
    parameter int N_WRITE     = 4,
    parameter int WADDR_WIDTH = 7
) (
    input logic                           clk,
    input logic                           rst_n,
    input logic [N_WRITE-1:0]             WriteEnable,
    input logic [N_WRITE*WADDR_WIDTH-1:0] WriteAddr
);
    // Flag any enabled write port presenting an unknown address.
    always @(posedge clk) begin
        if (rst_n) begin
            for (int p = 0; p < N_WRITE; p++) begin
                if (WriteEnable[p]) begin
                    assert (!$isunknown(WriteAddr[p*WADDR_WIDTH+:WADDR_WIDTH]));
                end
            end
        end
    end
endmodule

module register_file_4w_32b_1r_128b #(
    parameter int RADDR_WIDTH = 5,
    parameter int RDATA_WIDTH = 128,
    parameter int WDATA_WIDTH = 32,
    parameter int WADDR_WIDTH = RADDR_WIDTH + $clog2(RDATA_WIDTH / WDATA_WIDTH),
    parameter int N_WRITE     = 4
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 ReadEnable,
    input  logic [RADDR_WIDTH-1:0]               ReadAddr,
    output logic [RDATA_WIDTH-1:0]               ReadData,
    input  logic [N_WRITE-1:0]                   WriteEnable,
    input  logic [N_WRITE*WADDR_WIDTH-1:0]       WriteAddr,
    input  logic [N_WRITE*WDATA_WIDTH-1:0]       WriteData,
    input  logic [N_WRITE*(WDATA_WIDTH/8)-1:0]   WriteBE
);
    localparam int WPR       = RDATA_WIDTH / WDATA_WIDTH;
    localparam int LANE_W    = $clog2(WPR);
    localparam int NUM_WORDS = 2 ** WADDR_WIDTH;
    localparam int BE_W      = WDATA_WIDTH / 8;

    logic [WDATA_WIDTH-1:0]           mem_r [NUM_WORDS];
    logic [N_WRITE-1:0]               stg_valid_r;
    logic [N_WRITE*WADDR_WIDTH-1:0]   stg_addr_r;
    logic [N_WRITE*WDATA_WIDTH-1:0]   stg_data_r;
    logic [N_WRITE*BE_W-1:0]          stg_be_r;
    logic [RADDR_WIDTH-1:0]           raddr_r;
    logic [RDATA_WIDTH-1:0]           read_data_s;

    // Stage 1: capture each requesting port; idle ports drop their valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stg_valid_r <= '0;
            stg_addr_r  <= '0;
            stg_data_r  <= '0;
            stg_be_r    <= '0;
        end else begin
            stg_valid_r <= WriteEnable;
            for (int p = 0; p < N_WRITE; p++) begin
                if (WriteEnable[p]) begin
                    stg_addr_r[p*WADDR_WIDTH+:WADDR_WIDTH] <= WriteAddr[p*WADDR_WIDTH+:WADDR_WIDTH];
                    stg_data_r[p*WDATA_WIDTH+:WDATA_WIDTH] <= WriteData[p*WDATA_WIDTH+:WDATA_WIDTH];
                    stg_be_r[p*BE_W+:BE_W]                 <= WriteBE[p*BE_W+:BE_W];
                end
            end
        end
    end

    // Stage 2: commit bytes; ascending port order lets later (higher) ports override.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int w = 0; w < NUM_WORDS; w++) begin
                mem_r[w] <= '0;
            end
        end else begin
            for (int p = 0; p < N_WRITE; p++) begin
                for (int b = 0; b < BE_W; b++) begin
                    if (stg_valid_r[p] && stg_be_r[p*BE_W+b]) begin
                        mem_r[stg_addr_r[p*WADDR_WIDTH+:WADDR_WIDTH]][b*8+:8] <=
                            stg_data_r[p*WDATA_WIDTH+b*8+:8];
                    end
                end
            end
        end
    end

    // Read row address register, held until the next enabled capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            raddr_r <= '0;
        end else if (ReadEnable) begin
            raddr_r <= ReadAddr;
        end else begin
            raddr_r <= raddr_r;
        end
    end

    // Gather the lanes of the held row straight from storage (no staging bypass).
    always_comb begin
        read_data_s = '0;
        for (int j = 0; j < WPR; j++) begin
            read_data_s[j*WDATA_WIDTH+:WDATA_WIDTH] = mem_r[{raddr_r, LANE_W'(j)}];
        end
    end

    assign ReadData = read_data_s;

    register_file_4w_32b_1r_128b_chk #(
        .N_WRITE     (N_WRITE),
        .WADDR_WIDTH (WADDR_WIDTH)
    ) u_chk (
        .clk         (clk),
        .rst_n       (rst_n),
        .WriteEnable (WriteEnable),
        .WriteAddr   (WriteAddr)
    );
endmodule
